// File: rtl/spi_loopback_pkg.sv
// Purpose: shared op encodings and field widths for the SPI loopback queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_loopback_pkg;

    // Width of the op field at the top of every request/response message.
    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ECHO = 2'b00,
        OP_INV  = 2'b01,
        OP_INC  = 2'b10,
        OP_STAT = 2'b11
    } op_e;

endpackage

// File: rtl/spi_loopback_fifo.sv
// Purpose: DEPTH-entry circular FIFO (storage, read/write pointers, occupancy count).
// Latency: 1 cycle from enqueue to head; no write-to-read bypass.
// Backpressure: enq_rdy low when full (even if a dequeue happens that cycle); both handshakes blocked during reset.
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   enq_vld/enq_rdy/enq_dat       - write side handshake and data
//   deq_vld/deq_rdy/deq_dat       - read side handshake and head data (zero when empty)
//   count                         - number of stored entries
module spi_loopback_fifo #(
    parameter  int WIDTH = 30,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq_vld,
    output logic             enq_rdy,
    input  logic [WIDTH-1:0] enq_dat,
    output logic             deq_vld,
    input  logic             deq_rdy,
    output logic [WIDTH-1:0] deq_dat,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             enq_fire;
    logic             deq_fire;

    // Full/empty come from the count, never from pointer equality, since the
    // pointers are equal in both states.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Gating with reset keeps the neighbours from seeing a handshake on a
    // cycle where the queue is being flushed.
    assign enq_rdy  = !reset && !full;
    assign deq_vld  = !reset && !empty;
    assign deq_dat  = deq_vld ? mem[rd_ptr] : '0;

    assign enq_fire = enq_vld && enq_rdy;
    assign deq_fire = deq_vld && deq_rdy;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; stale contents are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_dat;
        end
    end

endmodule

// File: rtl/spi_loopback_queue.sv
// Purpose: SPI minion loopback that transforms each request (echo/invert/increment/status) and queues the response.
// Latency: 1 cycle minimum from request accept to response valid.
// Backpressure: recv_rdy low while DEPTH responses are queued; responses held stable until send_rdy.
//
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   recv_val/recv_rdy/recv_msg    - request from the SPI minion adapter (op in top 2 bits)
//   send_val/send_rdy/send_msg    - response to the SPI minion adapter (zero when idle)
//   count                         - number of queued responses
module spi_loopback_queue
    import spi_loopback_pkg::*;
#(
    parameter  int NBITS = 32,
    parameter  int DEPTH = 4,
    localparam int MW    = NBITS - 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    output logic          recv_rdy,
    input  logic [MW-1:0] recv_msg,
    output logic          send_val,
    input  logic          send_rdy,
    output logic [MW-1:0] send_msg,
    output logic [CW-1:0] count
);

    localparam int PW = MW - OP_W;

    op_e           op;
    logic [PW-1:0] payload;
    logic [MW-1:0] resp_dat;

    assign op      = op_e'(recv_msg[MW-1:MW-OP_W]);
    assign payload = recv_msg[PW-1:0];

    // The response is computed at enqueue time. Status reads the registered
    // count, i.e. the occupancy before this enqueue and any same-cycle dequeue.
    always_comb begin
        resp_dat = recv_msg;
        case (op)
            OP_ECHO: resp_dat = recv_msg;
            OP_INV:  resp_dat = {recv_msg[MW-1:MW-OP_W], ~payload};
            OP_INC:  resp_dat = {recv_msg[MW-1:MW-OP_W], payload + PW'(1)};
            OP_STAT: resp_dat = {recv_msg[MW-1:MW-OP_W], PW'(count)};
            default: resp_dat = recv_msg;
        endcase
    end

    spi_loopback_fifo #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_vld (recv_val),
        .enq_rdy (recv_rdy),
        .enq_dat (resp_dat),
        .deq_vld (send_val),
        .deq_rdy (send_rdy),
        .deq_dat (send_msg),
        .count   (count)
    );

endmodule

// File: tb/tb_spi_loopback_queue.sv
// Purpose: scoreboard bench for spi_loopback_queue (NBITS=32, DEPTH=4) with directed vectors.
// Latency: stimulus on falling edge, checks 1-2 time units later.
// Backpressure: exercises full queue, stalled head, simultaneous enqueue/dequeue and mid-stream reset.
module tb_spi_loopback_queue;

    localparam int NBITS = 32;
    localparam int DEPTH = 4;
    localparam int MW    = NBITS - 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          recv_val = 1'b0;
    logic          recv_rdy;
    logic [MW-1:0] recv_msg = '0;
    logic          send_val;
    logic          send_rdy = 1'b0;
    logic [MW-1:0] send_msg;
    logic [CW-1:0] count;

    logic [MW-1:0] exp_q [$];
    int            mc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    spi_loopback_queue #(
        .NBITS (NBITS),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .count    (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; e is the hand-computed response if the request is accepted.
    task automatic cyc(input logic v, input logic [MW-1:0] m, input logic sr, input logic [MW-1:0] e);
        bit enq;
        bit deq;
        @(negedge clk);
        reset    = 1'b0;
        recv_val = v;
        recv_msg = m;
        send_rdy = sr;
        #1;
        chk("count", 32'(count), 32'(mc));
        chk("recv_rdy", 32'(recv_rdy), 32'(mc != DEPTH));
        chk("send_val", 32'(send_val), 32'(mc != 0));
        if (mc == 0) begin
            chk("idle_msg", 32'(send_msg), 32'h0);
        end else if (!sr && exp_q.size() != 0) begin
            chk("hold_msg", 32'(send_msg), 32'(exp_q[0]));
        end
        enq = v && (mc != DEPTH);
        deq = sr && (mc != 0);
        if (enq) begin
            exp_q.push_back(e);
        end
        mc = mc + int'(enq) - int'(deq);
    endtask

    // Reset with both handshake inputs asserted; nothing may transfer.
    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        recv_val = 1'b1;
        recv_msg = 30'h0000_0077;
        send_rdy = 1'b1;
        mc = 0;
        exp_q.delete();
        repeat (n) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on every completed response handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && send_val && send_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got send_msg 0x%08h, required no response", send_msg);
                end else begin
                    chk("resp", 32'(send_msg), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] w;

        do_reset(2);
        cyc(1'b0, 30'h0, 1'b0, 30'h0);                       // reset state

        // echo, 1-cycle latency
        cyc(1'b1, 30'h0000_0005, 1'b1, 30'h0000_0005);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);
        // invert
        cyc(1'b1, 30'h1000_00AB, 1'b1, 30'h1FFF_FF54);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);
        // increment, wrap and non-wrap
        cyc(1'b1, 30'h2FFF_FFFF, 1'b1, 30'h2000_0000);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);
        cyc(1'b1, 30'h2000_0010, 1'b1, 30'h2000_0011);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);

        // status after two stalled echoes, then fill to full
        cyc(1'b1, 30'h0000_0011, 1'b0, 30'h0000_0011);
        cyc(1'b1, 30'h0000_0022, 1'b0, 30'h0000_0022);
        cyc(1'b1, 30'h3000_0000, 1'b0, 30'h3000_0002);
        cyc(1'b1, 30'h0000_0033, 1'b0, 30'h0000_0033);
        cyc(1'b1, 30'h0000_0044, 1'b0, 30'h0000_0044);       // refused: full
        cyc(1'b1, 30'h0000_0055, 1'b1, 30'h0000_0055);       // full: dequeue only
        cyc(1'b1, 30'h0000_0066, 1'b1, 30'h0000_0066);       // enq+deq, count held
        cyc(1'b0, 30'h0, 1'b0, 30'h0);                       // stalled head stays put
        cyc(1'b0, 30'h0, 1'b0, 30'h0);
        for (int k = 0; k < 8 && mc != 0; k++) cyc(1'b0, 30'h0, 1'b1, 30'h0);

        // status with a same-cycle dequeue reports pre-dequeue count; payload ignored
        cyc(1'b1, 30'h0000_0001, 1'b0, 30'h0000_0001);
        cyc(1'b1, 30'h0000_0002, 1'b0, 30'h0000_0002);
        cyc(1'b1, 30'h3ABC_DEF0, 1'b1, 30'h3000_0002);
        for (int k = 0; k < 8 && mc != 0; k++) cyc(1'b0, 30'h0, 1'b1, 30'h0);
        cyc(1'b1, 30'h3FFF_FFFF, 1'b1, 30'h3000_0000);       // status when empty
        cyc(1'b0, 30'h0, 1'b1, 30'h0);

        // streaming through several pointer wraps
        for (int i = 0; i < 10; i++) begin
            w = 30'(32'h0012_3400 + 32'(i));
            cyc(1'b1, w, 1'b1, w);
        end
        cyc(1'b0, 30'h0, 1'b1, 30'h0);

        // reset mid-stream with three queued responses
        cyc(1'b1, 30'h0000_000A, 1'b0, 30'h0000_000A);
        cyc(1'b1, 30'h0000_000B, 1'b0, 30'h0000_000B);
        cyc(1'b1, 30'h0000_000C, 1'b0, 30'h0000_000C);
        do_reset(1);
        cyc(1'b0, 30'h0, 1'b0, 30'h0);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);
        cyc(1'b0, 30'h0, 1'b1, 30'h0);
        cyc(1'b1, 30'h1000_0000, 1'b1, 30'h1FFF_FFFF);
        for (int k = 0; k < 8 && mc != 0; k++) cyc(1'b0, 30'h0, 1'b1, 30'h0);

        begin
            int budget;
            budget = 0;
            while (exp_q.size() != 0 && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            @(negedge clk);
            #3;
            chk("drained", 32'(exp_q.size()), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
